// File: rtl/invaes_round_ctrl_pkg.sv
// Shared types and constants for the inverse-AES round sequencer.
package invaes_pkg;

  localparam int NROUNDS = 10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KEXP, S_INIT, S_ROUND, S_FINAL, S_DONE
  } ctrl_state_t;

  typedef enum logic [1:0] {
    KEY_HOLD = 2'b00,
    KEY_FWD  = 2'b01,
    KEY_INV  = 2'b10
  } key_op_t;

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_ARK  = 2'b01,
    ST_FULL = 2'b10,
    ST_LAST = 2'b11
  } st_op_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round-constant lookup; indices outside 1..10 give 0.
  function automatic logic [7:0] rcon_lu(input logic [3:0] idx);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= 10; i++)
      if (idx == 4'(i)) v = RCON[i];
    return v;
  endfunction

endpackage

// File: rtl/invaes_round_ctrl_sync2.sv
// Generic two-flop synchronizer, async active-high reset, flops clear to 0.
module sync2 #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/invaes_round_ctrl.sv
// Round sequencer for the AES-128 inverse cipher: waits for the SPI transfer
// to end (falling edge of load), expands the key forward to rk10, then walks
// the state back through the initial AddRoundKey, nine full rounds and the
// final round. All outputs are registered.
module invaes_round_ctrl #(
  parameter int NROUNDS = invaes_pkg::NROUNDS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  output logic       ld,
  output logic [1:0] key_op,
  output logic [7:0] rcon,
  output logic [1:0] st_op,
  output logic [3:0] round,
  output logic       done
);
  import invaes_pkg::*;

  localparam logic [3:0] LAST = 4'(NROUNDS);

  ctrl_state_t r_state;
  key_op_t     r_key_op;
  st_op_t      r_st_op;
  logic [3:0]  r_cnt;
  logic [7:0]  r_rcon;
  logic        r_ld;
  logic        r_done;
  logic        r_load_q;
  logic        w_load_s;
  logic        w_start;
  logic        w_busy;

  sync2 #(.W(1)) u_load_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (load),
    .o_q   (w_load_s)
  );

  // Previous synchronized load sample, for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_load_q <= 1'b0;
    else       r_load_q <= w_load_s;
  end

  assign w_start = r_load_q & ~w_load_s;
  assign w_busy  = (r_state inside {S_LOAD, S_KEXP, S_INIT, S_ROUND, S_FINAL});

  // Sequencer: state, shared up/down round counter and registered op outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_ld     <= 1'b0;
      r_key_op <= KEY_HOLD;
      r_st_op  <= ST_HOLD;
      r_rcon   <= 8'h00;
      r_done   <= 1'b0;
    end else begin
      r_ld     <= 1'b0;
      r_key_op <= KEY_HOLD;
      r_st_op  <= ST_HOLD;
      r_rcon   <= 8'h00;
      if (w_busy && w_load_s) begin
        // A new transfer started under us: drop everything and wait for its end.
        r_state <= S_IDLE;
        r_cnt   <= 4'd0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_done <= 1'b0;
            if (w_start) begin
              r_state <= S_LOAD;
              r_cnt   <= 4'd0;
              r_ld    <= 1'b1;
            end
          end
          S_LOAD: begin
            r_state  <= S_KEXP;
            r_cnt    <= 4'd1;
            r_key_op <= KEY_FWD;
            r_rcon   <= rcon_lu(4'd1);
          end
          S_KEXP: begin
            if (r_cnt == LAST) begin
              // Key register now holds rk10; counter stays at 10 for INIT.
              r_state <= S_INIT;
              r_st_op <= ST_ARK;
            end else begin
              r_cnt    <= r_cnt + 4'd1;
              r_key_op <= KEY_FWD;
              r_rcon   <= rcon_lu(r_cnt + 4'd1);
            end
          end
          S_INIT: begin
            // Inverse step to round r needs the constant of round r+1.
            r_state  <= S_ROUND;
            r_cnt    <= LAST - 4'd1;
            r_key_op <= KEY_INV;
            r_st_op  <= ST_FULL;
            r_rcon   <= rcon_lu(LAST);
          end
          S_ROUND: begin
            r_key_op <= KEY_INV;
            r_rcon   <= rcon_lu(r_cnt);
            r_cnt    <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= S_FINAL;
              r_st_op <= ST_LAST;
            end else begin
              r_st_op <= ST_FULL;
            end
          end
          S_FINAL: begin
            r_state <= S_DONE;
            r_cnt   <= 4'd0;
            r_done  <= 1'b1;
          end
          S_DONE: begin
            if (w_load_s) begin
              r_state <= S_IDLE;
              r_done  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ld     = r_ld;
  assign key_op = r_key_op;
  assign rcon   = r_rcon;
  assign st_op  = r_st_op;
  assign round  = r_cnt;
  assign done   = r_done;

endmodule

// File: tb/tb_invaes_round_ctrl.sv
// Scoreboard bench for invaes_round_ctrl: stimulus pushes the expected
// per-cycle op vectors, a negedge monitor pops one whenever the DUT shows
// activity (any nonzero op/rcon/round, or a change of done).
module tb_invaes_round_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       ld;
  logic [1:0] key_op;
  logic [7:0] rcon;
  logic [1:0] st_op;
  logic [3:0] round;
  logic       done;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  typedef struct packed {
    int          c;
    logic [17:0] v;
  } exp_t;

  exp_t        expq[$];
  logic [17:0] m_act;
  logic        done_q = 1'b0;
  logic [7:0]  RC [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  invaes_round_ctrl #(.NROUNDS(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .ld     (ld),
    .key_op (key_op),
    .rcon   (rcon),
    .st_op  (st_op),
    .round  (round),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [17:0] pk(input logic l, input logic [1:0] k,
                                     input logic [7:0] rc, input logic [1:0] s,
                                     input logic [3:0] rd, input logic d);
    return {l, k, rc, s, rd, d};
  endfunction

  task automatic push_ev(input int c, input int stop, input logic [17:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    if (c <= stop) expq.push_back(e);
  endtask

  // Full decrypt sequence for a raw load fall at cycle e, truncated at stop.
  task automatic push_run(input int e, input int stop);
    push_ev(e + 3, stop, pk(1'b1, 2'd0, 8'h00, 2'd0, 4'd0, 1'b0));
    for (int k = 1; k <= 10; k++)
      push_ev(e + 3 + k, stop, pk(1'b0, 2'd1, RC[k], 2'd0, 4'(k), 1'b0));
    push_ev(e + 14, stop, pk(1'b0, 2'd0, 8'h00, 2'd1, 4'd10, 1'b0));
    for (int r = 9; r >= 1; r--)
      push_ev(e + 24 - r, stop, pk(1'b0, 2'd2, RC[r + 1], 2'd2, 4'(r), 1'b0));
    push_ev(e + 24, stop, pk(1'b0, 2'd2, 8'h01, 2'd3, 4'd0, 1'b0));
    push_ev(e + 25, stop, pk(1'b0, 2'd0, 8'h00, 2'd0, 4'd0, 1'b1));
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {14'd0, ld, key_op, rcon, st_op, round, done}, 32'd0);
  endtask

  // Raise load while in DONE: done must drop 3 cycles later.
  task automatic leave_done();
    load = 1'b1;
    push_ev(cyc + 3, cyc + 3, 18'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_fall", {31'd0, done}, 32'd0);
  endtask

  // Monitor: every active cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    m_act = {ld, key_op, rcon, st_op, round, done};
    if (ld || key_op != 2'd0 || rcon != 8'h00 || st_op != 2'd0 ||
        round != 4'd0 || done != done_q) begin
      if (expq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_activity: got %h expected no activity (cycle %0d)", m_act, cyc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("event_cycle", cyc, e.c);
        chk("event_ops", {14'd0, m_act}, {14'd0, e.v});
      end
    end
    done_q = done;
  end

  initial begin
    int e;
    load  = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    reset = 1'b0;

    // Low load out of reset must never start a run.
    repeat (50) @(posedge clk);
    #1;
    chk_zero("idle_50");

    // Long transfer then fall: full run.
    load = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    load = 1'b0;
    e = cyc;
    push_run(e, e + 25);
    repeat (30) @(posedge clk);
    #1;
    chk("run1_done", {31'd0, done}, 32'd1);

    // Second transfer out of DONE.
    leave_done();
    load = 1'b0;
    e = cyc;
    push_run(e, e + 25);
    repeat (30) @(posedge clk);
    #1;
    chk("run2_done", {31'd0, done}, 32'd1);

    // Abort in KEXP step 5.
    leave_done();
    load = 1'b0;
    e = cyc;
    push_run(e, e + 10);
    repeat (8) @(posedge clk);
    #1;
    load = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk_zero("abort_idle");
    load = 1'b0;
    e = cyc;
    push_run(e, e + 25);
    repeat (30) @(posedge clk);
    #1;
    chk("run3_done", {31'd0, done}, 32'd1);

    // Async reset while round=5 in ROUND.
    leave_done();
    load = 1'b0;
    e = cyc;
    push_run(e, e + 19);
    repeat (19) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("reset_async");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_zero("post_reset_idle");
    load = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    load = 1'b0;
    e = cyc;
    push_run(e, e + 25);
    repeat (30) @(posedge clk);
    #1;
    chk("run4_done", {31'd0, done}, 32'd1);

    chk("queue_drained", expq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
